// File: rtl/rsa_pkg.sv
// Shared constants for the RSA exponentiation datapath: operand-select codes
// and the Montgomery multiplier state encoding.
package rsa_pkg;

    localparam logic [1:0] SEL1_INIT = 2'b00;
    localparam logic [1:0] SEL1_MULT = 2'b01;
    localparam logic [1:0] SEL1_CONV = 2'b10;

    localparam logic SEL2_INIT = 1'b0;
    localparam logic SEL2_SQR  = 1'b1;

    typedef enum logic [1:0] {
        MMM_IDLE = 2'b00,
        MMM_RUN  = 2'b01,
        MMM_DONE = 2'b10
    } mmm_state_e;

endpackage

// File: rtl/mmm_serial.sv
// Bit-serial Montgomery multiplier: res = a*b*2^-WIDTH mod m after WIDTH
// iterations, with a final conditional subtraction on the output.
module mmm_serial
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] res,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    mmm_state_e       r_state;
    mmm_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH+1:0] r_t;
    logic [CW-1:0]    r_iter;

    logic [WIDTH+2:0] w_u;
    logic [WIDTH+2:0] w_v;
    logic [WIDTH+1:0] w_t_nxt;
    logic [WIDTH+1:0] w_diff;
    logic             w_q;
    logic             w_last;
    logic             w_ge;

    // One extra headroom bit above T so the u + q*M sum never wraps.
    always_comb begin
        w_u     = {1'b0, r_t} + (r_a[0] ? {3'b000, r_b} : '0);
        w_q     = w_u[0];
        w_v     = w_u + (w_q ? {3'b000, m} : '0);
        w_t_nxt = w_v[WIDTH+2:1];
    end

    assign w_last = (r_iter == CW'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = MMM_RUN;
        end else if (!clr_n) begin
            w_state_nxt = MMM_IDLE;
        end else begin
            case (r_state)
                MMM_RUN:  if (w_last) w_state_nxt = MMM_DONE;
                MMM_DONE: w_state_nxt = MMM_DONE;
                default:  w_state_nxt = MMM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= MMM_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_t     <= '0;
            r_iter  <= '0;
        end else if (en) begin
            r_state <= w_state_nxt;
            if (start) begin
                r_a    <= a;
                r_b    <= b;
                r_t    <= '0;
                r_iter <= '0;
            end else if (!clr_n) begin
                r_t    <= '0;
                r_iter <= '0;
            end else if (r_state == MMM_RUN) begin
                r_t    <= w_t_nxt;
                r_a    <= r_a >> 1;
                r_iter <= r_iter + CW'(1);
            end
        end
    end

    assign w_ge   = (r_t >= {2'b00, m});
    assign w_diff = r_t - {2'b00, m};
    assign res    = w_ge ? w_diff[WIDTH-1:0] : r_t[WIDTH-1:0];
    assign busy   = (r_state == MMM_RUN);

endmodule

// File: rtl/rsa_datapath.sv
// RSA exponentiation datapath: reg1/reg2, two Montgomery multipliers, result.
// Optional overrun flag is compiled in with RSA_DATAPATH_OVERRUN_EN.
module rsa_datapath
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             rst_mmm,
    input  logic             ld_a,
    input  logic             ld_r,
    input  logic             lock1,
    input  logic             lock2,
    input  logic [1:0]       sel1,
    input  logic             sel2,
    input  logic             eoc,
    input  logic [WIDTH-1:0] msg,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] result,
    output logic             done
`ifdef RSA_DATAPATH_OVERRUN_EN
    ,
    output logic             ovr
`endif
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_reg1;
    logic [WIDTH-1:0] r_reg2;
    logic [WIDTH-1:0] r_result;
    logic             r_eoc;
    logic             r_done;

    logic [WIDTH-1:0] w_a1;
    logic [WIDTH-1:0] w_b1;
    logic [WIDTH-1:0] w_a2;
    logic [WIDTH-1:0] w_b2;
    logic [WIDTH-1:0] w_res1;
    logic [WIDTH-1:0] w_res2;
    logic             w_busy1;
    logic             w_busy2;

    always_comb begin
        w_a1 = r2;
        w_b1 = ONE;
        case (sel1)
            SEL1_INIT: begin
                w_a1 = r2;
                w_b1 = ONE;
            end
            SEL1_MULT: begin
                w_a1 = r_reg1;
                w_b1 = r_reg2;
            end
            default: begin
                w_a1 = r_reg1;
                w_b1 = ONE;
            end
        endcase
    end

    always_comb begin
        w_a2 = msg;
        w_b2 = r2;
        if (sel2 == SEL2_SQR) begin
            w_a2 = r_reg2;
            w_b2 = r_reg2;
        end
    end

    // ld_a/ld_r/eoc are single-cycle strobes from the controller, honoured
    // only when en is high; there is no back-pressure towards the controller.
    mmm_serial #(.WIDTH(WIDTH)) u_mmm1 (
        .clk   (clk),
        .rstb  (rstb),
        .en    (en),
        .clr_n (rst_mmm),
        .start (ld_a),
        .a     (w_a1),
        .b     (w_b1),
        .m     (modulus),
        .res   (w_res1),
        .busy  (w_busy1)
    );

    mmm_serial #(.WIDTH(WIDTH)) u_mmm2 (
        .clk   (clk),
        .rstb  (rstb),
        .en    (en),
        .clr_n (rst_mmm),
        .start (ld_a),
        .a     (w_a2),
        .b     (w_b2),
        .m     (modulus),
        .res   (w_res2),
        .busy  (w_busy2)
    );

    // A simultaneous ld_a only reloads the multipliers on this edge, so ld_r
    // still captures the results of the previous operation.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_reg1   <= '0;
            r_reg2   <= '0;
            r_eoc    <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (en) begin
            if (ld_r && lock1) r_reg1 <= w_res1;
            if (ld_r && lock2) r_reg2 <= w_res2;
            r_eoc  <= eoc;
            r_done <= r_eoc;
            if (r_eoc) r_result <= r_reg1;
        end
    end

    assign result = r_result;
    assign done   = r_done;

`ifdef RSA_DATAPATH_OVERRUN_EN
    logic r_ovr;

    // A fresh overrun wins over the clear when both occur on one edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_ovr <= 1'b0;
        end else if (en) begin
            if ((ld_a || ld_r) && (w_busy1 || w_busy2)) begin
                r_ovr <= 1'b1;
            end else if (ld_a && (sel1 == SEL1_INIT)) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign ovr = r_ovr;
`else
    logic w_unused_busy;
    assign w_unused_busy = w_busy1 | w_busy2;
`endif

endmodule

// File: tb/tb_rsa_datapath.sv
// Directed bench for rsa_datapath: drives the exponentiation control sequence
// and checks result/done against a modular-arithmetic reference model.
module tb_rsa_datapath;

    localparam int W = 8;
    localparam int MOD = 187;
    localparam int R2 = 86;
    localparam int STALL = 5;

    logic         clk = 1'b0;
    logic         rstb = 1'b1;
    logic         en = 1'b0;
    logic         rst_mmm = 1'b1;
    logic         ld_a = 1'b0;
    logic         ld_r = 1'b0;
    logic         lock1 = 1'b0;
    logic         lock2 = 1'b0;
    logic [1:0]   sel1 = 2'b00;
    logic         sel2 = 1'b0;
    logic         eoc = 1'b0;
    logic [W-1:0] msg = '0;
    logic [W-1:0] modulus = W'(MOD);
    logic [W-1:0] r2 = W'(R2);
    logic [W-1:0] result;
    logic         done;
`ifdef RSA_DATAPATH_OVERRUN_EN
    logic         ovr;
`endif

    rsa_datapath #(.WIDTH(W)) dut (
        .clk     (clk),
        .rstb    (rstb),
        .en      (en),
        .rst_mmm (rst_mmm),
        .ld_a    (ld_a),
        .ld_r    (ld_r),
        .lock1   (lock1),
        .lock2   (lock2),
        .sel1    (sel1),
        .sel2    (sel2),
        .eoc     (eoc),
        .msg     (msg),
        .modulus (modulus),
        .r2      (r2),
        .result  (result),
        .done    (done)
`ifdef RSA_DATAPATH_OVERRUN_EN
        ,
        .ovr     (ovr)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int modexp(input int b, input int e, input int m);
        longint r = 1;
        longint x = b % m;
        for (int i = 0; i < 31; i++) begin
            if (((e >> i) & 1) == 1) r = (r * x) % m;
            x = (x * x) % m;
        end
        return int'(r);
    endfunction

    // Montgomery product a*b*R^-1 mod m, found by search.
    function automatic int mont(input int a, input int b, input int m);
        for (int x = 0; x < m; x++) begin
            if ((longint'(x) * 256) % m == (longint'(a) * b) % m) return x;
        end
        return -1;
    endfunction

    int           cur_exp = 0;
    logic         m_pend = 1'b0;
    int           m_pend_val = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_result = '0;

    // done follows a sampled eoc by one enabled cycle and publishes reg1.
    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_pend   <= 1'b0;
            m_done   <= 1'b0;
            m_result <= '0;
        end else if (en) begin
            m_done <= m_pend;
            if (m_pend) m_result <= W'(m_pend_val);
            m_pend     <= eoc;
            m_pend_val <= cur_exp;
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic done_seen = 1'b0;
    int   done_cycle = 0;
    always @(negedge clk) begin
        check("done", {63'd0, done}, {63'd0, m_done});
        check("result", {56'd0, result}, {56'd0, m_result});
        if (done === 1'b1) begin
            done_seen  = 1'b1;
            done_cycle = cycle_cnt;
        end
    end

    // ---------------- driver tasks ----------------
    int   run_cyc = 0;
    int   stall_at = -1;
    int   abort_at = -1;
    logic aborted = 1'b0;

    task automatic tick();
        if (aborted) begin
            ld_a = 0; ld_r = 0; eoc = 0; lock1 = 0; lock2 = 0; rst_mmm = 1;
            return;
        end
        @(posedge clk);
        #1;
        ld_a = 0; ld_r = 0; eoc = 0; lock1 = 0; lock2 = 0; rst_mmm = 1;
        run_cyc++;
        if (run_cyc == stall_at) begin
            en = 0;
            repeat (STALL) @(posedge clk);
            #1;
            en = 1;
        end
        if (run_cyc == abort_at) begin
            rstb = 0;
            #1;
            check("abort_result_clear", {56'd0, result}, 64'd0);
            check("abort_no_done", {63'd0, done}, 64'd0);
            aborted = 1;
        end
    endtask

    task automatic stage(input logic [1:0] s1, input logic s2, input logic l1, input logic l2);
        sel1 = s1; sel2 = s2; ld_a = 1;
        tick();
        repeat (9) tick();
        lock1 = l1; lock2 = l2; ld_r = 1;
        tick();
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = -1;
        if (aborted) return;
        for (int k = 0; k < 4 && !done_seen; k++) begin
            @(negedge clk);
            #1;
        end
        check("done_timeout", {63'd0, done_seen}, 64'd1);
        if (done_seen) lat = done_cycle - start;
    endtask

    task automatic fire_eoc(input int expv, input int start, output int lat);
        cur_exp = expv; done_seen = 0; eoc = 1;
        tick();
        wait_done(start, lat);
    endtask

    task automatic run_exp(input int m_in, input int e, output int lat);
        int start;
        msg = W'(m_in); run_cyc = 0; aborted = 0; start = cycle_cnt;
        stage(2'b00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 31 && (e >> i) != 0; i++)
            stage(2'b01, 1'b1, ((e >> i) & 1) == 1, 1'b1);
        stage(2'b10, 1'b0, 1'b1, 1'b0);
        fire_eoc(modexp(m_in, e, MOD), start, lat);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int lat_a, lat_b, lat_x;
        #1 rstb = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", {56'd0, result}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        rstb = 1; en = 1;

        // Pin the model to hand-computed values.
        check("model_mont_one", 64'(mont(R2, 1, MOD)), 64'd69);
        check("model_encrypt", 64'(modexp(88, 7, MOD)), 64'd11);
        check("model_decrypt", 64'(modexp(11, 23, MOD)), 64'd88);

        // Isolated multiply; ld_a overrides a same-cycle rst_mmm, ld_r at the latency edge.
        run_cyc = 0;
        sel1 = 2'b00; sel2 = 1'b0; ld_a = 1; rst_mmm = 0;
        tick();
        repeat (8) tick();
        ld_r = 1; lock1 = 1;
        tick();
        fire_eoc(mont(R2, 1, MOD), cycle_cnt, lat_x);
        check("iso_mont_one", {56'd0, result}, 64'd69);

        // rst_mmm mid-run drops the accumulator to zero.
        sel1 = 2'b00; ld_a = 1;
        tick();
        repeat (3) tick();
        rst_mmm = 0;
        tick();
        repeat (6) tick();
        ld_r = 1; lock1 = 1;
        tick();
        fire_eoc(0, cycle_cnt, lat_x);
        check("rst_mmm_clear", {56'd0, result}, 64'd0);

        run_exp(88, 7, lat_a);
        check("encrypt", {56'd0, result}, 64'd11);
        run_exp(11, 23, lat_x);
        check("decrypt", {56'd0, result}, 64'd88);
        run_exp(88, 0, lat_x);
        check("exp_zero", {56'd0, result}, 64'd1);

        // Enable stall inside the second stage's RUN window.
        stall_at = $urandom_range(13, 18);
        run_exp(88, 7, lat_b);
        stall_at = -1;
        check("stall_result", {56'd0, result}, 64'd11);
        check("stall_delay", 64'(lat_b - lat_a), 64'(STALL));

        // Reset mid-run, then read reg1 back through eoc.
        abort_at = 60;
        run_exp(11, 23, lat_x);
        abort_at = -1;
        aborted = 0;
        @(posedge clk);
        #1;
        check("abort_hold_done", {63'd0, done}, 64'd0);
        rstb = 1;
        fire_eoc(0, cycle_cnt, lat_x);
        check("abort_reg1_zero", {56'd0, result}, 64'd0);
        run_exp(11, 23, lat_x);
        check("after_abort", {56'd0, result}, 64'd88);

`ifdef RSA_DATAPATH_OVERRUN_EN
        sel1 = 2'b00; sel2 = 1'b0; ld_a = 1;
        tick();
        tick();
        tick();
        ld_r = 1; lock1 = 1;
        tick();
        @(negedge clk);
        check("ovr_set", {63'd0, ovr}, 64'd1);
        repeat (8) tick();
        @(negedge clk);
        check("ovr_sticky", {63'd0, ovr}, 64'd1);
        sel1 = 2'b00; ld_a = 1;
        tick();
        @(negedge clk);
        check("ovr_clear", {63'd0, ovr}, 64'd0);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
